// File: rtl/mismatch_fault_monitor_if.sv
// Result-stream interface for mismatch_fault_monitor.
//   in_valid / in_sum / in_mismatch : checked results from the redundant adder
//   out_valid / out_data            : agreeing results forwarded downstream
// master drives the input stream and observes the output stream; slave is the monitor.
interface mismatch_fault_monitor_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic [W-1:0] in_sum;
  logic         in_mismatch;
  logic         out_valid;
  logic [W-1:0] out_data;

  modport master (output in_valid, in_sum, in_mismatch, input out_valid, out_data);
  modport slave  (input in_valid, in_sum, in_mismatch, output out_valid, out_data);
endinterface

// File: rtl/mismatch_fault_monitor.sv
// mismatch_fault_monitor
//   Watches the redundant-adder result stream. Agreeing results are forwarded with
//   one cycle of latency. Mismatching results are counted and never forwarded, and
//   the first one is captured. A per-window error count drives the OK/DEGRADED/FAULT
//   health FSM. FAULT is sticky and stops forwarding until clear_i.
// Ports
//   clk, rst_n           clock, async active-low reset
//   bus (slave)          in_valid/in_sum/in_mismatch in, out_valid/out_data out
//   clear_i              pulse: leave FAULT, drop capture, restart window
//   state_o              0=OK 1=DEGRADED 2=FAULT
//   degraded_o, fault_o  one-hot views of state_o
//   total_cnt_o          accepted samples (saturating)
//   err_cnt_o            mismatching samples (saturating)
//   first_err_valid_o    first_err_data_o holds a captured result
//   first_err_data_o     in_sum of the first mismatch since reset/clear
module mismatch_fault_monitor #(
  parameter int W          = 32,
  parameter int ERR_THRESH = 4,
  parameter int WINDOW     = 64,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mismatch_fault_monitor_if.slave   bus,
  input  logic                      clear_i,
  output logic [1:0]                state_o,
  output logic                      degraded_o,
  output logic                      fault_o,
  output logic [CNT_W-1:0]          total_cnt_o,
  output logic [CNT_W-1:0]          err_cnt_o,
  output logic                      first_err_valid_o,
  output logic [W-1:0]              first_err_data_o
);
  localparam int PW = $clog2(WINDOW);
  localparam int EW = $clog2(WINDOW + 1);  // win_err can reach WINDOW

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_DEGRADED = 2'd1;
  localparam logic [1:0] ST_FAULT    = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    win_pos_q, win_pos_d;
  logic [EW-1:0]    win_err_q, win_err_d;
  logic [CNT_W-1:0] total_q, total_d, err_q, err_d;
  logic             fe_valid_q, fe_valid_d;
  logic [W-1:0]     fe_data_q, fe_data_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;

  logic        sample, mm, closing;
  logic [31:0] err_next;

  assign sample   = bus.in_valid;
  assign mm       = bus.in_valid & bus.in_mismatch;
  assign closing  = (win_pos_q == PW'(WINDOW - 1));
  assign err_next = 32'(win_err_q) + 32'(mm);

  always_comb begin
    out_valid_d = sample & ~bus.in_mismatch & (state_q != ST_FAULT);
    out_data_d  = out_valid_d ? bus.in_sum : out_data_q;

    total_d = (sample && total_q != CNT_MAX) ? total_q + 1'b1 : total_q;
    err_d   = (mm && err_q != CNT_MAX) ? err_q + 1'b1 : err_q;

    // clear_i beats a same-cycle mismatch: nothing gets captured that cycle
    fe_valid_d = fe_valid_q;
    fe_data_d  = fe_data_q;
    if (clear_i) begin
      fe_valid_d = 1'b0;
    end else if (mm && !fe_valid_q) begin
      fe_valid_d = 1'b1;
      fe_data_d  = bus.in_sum;
    end

    state_d   = state_q;
    win_pos_d = win_pos_q;
    win_err_d = win_err_q;
    if (clear_i) begin
      state_d   = ST_OK;
      win_pos_d = '0;
      win_err_d = '0;
    end else if (sample && state_q != ST_FAULT) begin
      if (mm && err_next >= 32'(ERR_THRESH)) state_d = ST_FAULT;
      else if (mm)                           state_d = ST_DEGRADED;
      else if (state_q == ST_DEGRADED && closing) state_d = ST_OK;
      else if (state_q != ST_DEGRADED)       state_d = ST_OK;  // also scrubs unused code 3
      // window restarts after the closing sample has been judged
      if (closing) begin
        win_pos_d = '0;
        win_err_d = '0;
      end else begin
        win_pos_d = win_pos_q + 1'b1;
        win_err_d = err_next[EW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OK;
      win_pos_q   <= '0;
      win_err_q   <= '0;
      total_q     <= '0;
      err_q       <= '0;
      fe_valid_q  <= 1'b0;
      fe_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      win_pos_q   <= win_pos_d;
      win_err_q   <= win_err_d;
      total_q     <= total_d;
      err_q       <= err_d;
      fe_valid_q  <= fe_valid_d;
      fe_data_q   <= fe_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign state_o            = state_q;
  assign degraded_o         = (state_q == ST_DEGRADED);
  assign fault_o            = (state_q == ST_FAULT);
  assign total_cnt_o        = total_q;
  assign err_cnt_o          = err_q;
  assign first_err_valid_o  = fe_valid_q;
  assign first_err_data_o   = fe_data_q;
endmodule

// File: tb/tb_mismatch_fault_monitor.sv
// Directed bench for mismatch_fault_monitor (W=32, ERR_THRESH=4, WINDOW=64, CNT_W=16).
module tb_mismatch_fault_monitor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_i = 1'b0;
  logic [1:0]  state_o;
  logic        degraded_o, fault_o;
  logic [15:0] total_cnt_o, err_cnt_o;
  logic        first_err_valid_o;
  logic [31:0] first_err_data_o;

  int checks = 0;
  int errors = 0;

  mismatch_fault_monitor_if #(.W(32)) bus ();

  mismatch_fault_monitor #(.W(32), .ERR_THRESH(4), .WINDOW(64), .CNT_W(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus.slave),
    .clear_i           (clear_i),
    .state_o           (state_o),
    .degraded_o        (degraded_o),
    .fault_o           (fault_o),
    .total_cnt_o       (total_cnt_o),
    .err_cnt_o         (err_cnt_o),
    .first_err_valid_o (first_err_valid_o),
    .first_err_data_o  (first_err_data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one sample (or idle cycle when v=0); returns #1 after the capturing edge
  task automatic send(input logic v, input logic [31:0] d, input logic m, input logic clr);
    bus.in_valid    = v;
    bus.in_sum      = d;
    bus.in_mismatch = m;
    clear_i         = clr;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.in_mismatch = 1'b0;
    clear_i         = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) send(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_sum = '0; bus.in_mismatch = 1'b0;

    // T1 reset
    #12;
    chk("rst_state", state_o, 0);
    chk("rst_outv", bus.out_valid, 0);
    chk("rst_total", total_cnt_o, 0);
    chk("rst_fev", first_err_valid_o, 0);
    rst_n = 1'b1;
    repeat (3) send(1'b0, 32'h0, 1'b0, 1'b0);
    chk("idle_total", total_cnt_o, 0);
    chk("idle_outv", bus.out_valid, 0);

    // T2 clean forwarding
    for (int i = 0; i < 10; i++) begin
      send(1'b1, 32'h5 + 32'(i), 1'b0, 1'b0);
      chk("t2_outv", bus.out_valid, 1);
      chk("t2_data", bus.out_data, 32'h5 + 32'(i));
    end
    send(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t2_outv_drop", bus.out_valid, 0);
    chk("t2_data_hold", bus.out_data, 32'hE);
    chk("t2_total", total_cnt_o, 10);
    chk("t2_err", err_cnt_o, 0);
    chk("t2_state", state_o, 0);

    // T3 single mismatch -> DEGRADED until window closes
    do_reset();
    clean(3);
    send(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    chk("t3_outv", bus.out_valid, 0);
    chk("t3_state", state_o, 1);
    chk("t3_degr", degraded_o, 1);
    chk("t3_fev", first_err_valid_o, 1);
    chk("t3_fed", first_err_data_o, 32'hDEADBEEF);
    chk("t3_err", err_cnt_o, 1);
    clean(59);  // samples 4..62
    chk("t3_state_62", state_o, 1);
    clean(1);   // sample 63 closes window
    chk("t3_state_63", state_o, 0);
    chk("t3_total", total_cnt_o, 64);

    // T4 four mismatches -> FAULT, clear
    do_reset();
    send(1'b1, 32'h111, 1'b1, 1'b0);
    chk("t4_state1", state_o, 1);
    send(1'b1, 32'h222, 1'b1, 1'b0);
    send(1'b1, 32'h333, 1'b1, 1'b0);
    chk("t4_state3", state_o, 1);
    send(1'b1, 32'h444, 1'b1, 1'b0);
    chk("t4_state4", state_o, 2);
    chk("t4_fault", fault_o, 1);
    chk("t4_fed", first_err_data_o, 32'h111);
    send(1'b1, 32'h55, 1'b0, 1'b0);
    chk("t4_blocked", bus.out_valid, 0);
    chk("t4_sticky", state_o, 2);
    send(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t4_clr_state", state_o, 0);
    chk("t4_clr_fev", first_err_valid_o, 0);
    chk("t4_clr_fed", first_err_data_o, 32'h111);
    chk("t4_err", err_cnt_o, 4);
    send(1'b1, 32'h77, 1'b0, 1'b0);
    chk("t4_fwd", bus.out_valid, 1);
    chk("t4_fwd_d", bus.out_data, 32'h77);

    // T5 boundary: 4th mismatch on closing sample 63
    do_reset();
    clean(60);
    send(1'b1, 32'hA0, 1'b1, 1'b0);
    send(1'b1, 32'hA1, 1'b1, 1'b0);
    send(1'b1, 32'hA2, 1'b1, 1'b0);
    chk("t5_state62", state_o, 1);
    send(1'b1, 32'hA3, 1'b1, 1'b0);
    chk("t5_fault63", state_o, 2);
    // rerun: 4th mismatch lands in the next window
    do_reset();
    clean(60);
    send(1'b1, 32'hA0, 1'b1, 1'b0);
    send(1'b1, 32'hA1, 1'b1, 1'b0);
    send(1'b1, 32'hA2, 1'b1, 1'b0);
    clean(1);
    chk("t5_ok63", state_o, 0);
    send(1'b1, 32'hA4, 1'b1, 1'b0);
    chk("t5_degr64", state_o, 1);

    // T6 clear with simultaneous mismatch
    do_reset();
    for (int i = 0; i < 4; i++) send(1'b1, 32'hC0 + 32'(i), 1'b1, 1'b0);
    chk("t6_fault", state_o, 2);
    send(1'b1, 32'hABC, 1'b1, 1'b1);
    chk("t6_state", state_o, 0);
    chk("t6_err", err_cnt_o, 5);
    chk("t6_total", total_cnt_o, 5);
    chk("t6_fev", first_err_valid_o, 0);
    chk("t6_outv", bus.out_valid, 0);
    send(1'b1, 32'hBCD, 1'b1, 1'b0);
    chk("t6_after_state", state_o, 1);
    chk("t6_after_fed", first_err_data_o, 32'hBCD);

    // saturation
    do_reset();
    bus.in_valid = 1'b1; bus.in_mismatch = 1'b0; bus.in_sum = 32'h1;
    repeat (65535) @(posedge clk);
    #1;
    chk("sat_ffff", total_cnt_o, 16'hFFFF);
    @(posedge clk); #1;
    chk("sat_hold", total_cnt_o, 16'hFFFF);
    bus.in_valid = 1'b0;

    // async reset mid-FAULT
    do_reset();
    for (int i = 0; i < 4; i++) send(1'b1, 32'hE0 + 32'(i), 1'b1, 1'b0);
    chk("ar_fault", fault_o, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ar_state", state_o, 0);
    chk("ar_fault0", fault_o, 0);
    chk("ar_total", total_cnt_o, 0);
    chk("ar_err", err_cnt_o, 0);
    chk("ar_fev", first_err_valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
